c432_oracle_query_seq: RTL and testbench
========================================

Name: c432_oracle_query_seq

Overview:
- Query sequencer directly upstream of the camouflaged c432 netlist instance.
- Accepts a primary-input pattern plus a camouflage key (s_0,s_1) from the DeCam SAT host over valid/ready, drives them onto the c432 PIs/key pins, waits a fixed settle time, captures the 7 POs and returns the I/O pair to the host.
- One query in flight at a time; counts completed queries for the host's oracle-budget accounting.

Parameters:
- PI_W, 36, primary-input width (N1..N115 order, N1 = bit 0).
- PO_W, 7, primary-output width (N223,N329,N370,N421,N430,N431,N432; N223 = bit 0).
- KEY_W, 2, camouflage key width (s_0 = bit 0, s_1 = bit 1).
- SETTLE_CYC, 2, cycles between driving PIs and sampling POs; values below 1 are treated as 1.
- CNT_W, 16, query counter width.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- pat_valid, in, 1, host pattern valid.
- pat_ready, out, 1, sequencer can accept a pattern.
- pat_pi, in, PI_W, pattern to apply.
- pat_key, in, KEY_W, key to apply.
- dut_pi, out, PI_W, registered drive to c432 PIs.
- dut_key, out, KEY_W, registered drive to c432 key inputs.
- dut_po, in, PO_W, c432 POs (combinational from dut_pi/dut_key).
- rsp_valid, out, 1, response valid.
- rsp_ready, in, 1, host accepts response.
- rsp_pi, out, PI_W, echo of the applied pattern.
- rsp_po, out, PO_W, captured outputs.
- rsp_err, out, 1, query rejected (see Optional Feature; constant 0 otherwise).
- busy, out, 1, high in any state other than IDLE.
- cnt_clr, in, 1, synchronous clear of query_cnt.
- query_cnt, out, CNT_W, completed-response count.

Behaviour:
- Reset (async assert, sync release): state IDLE; pat_ready=1; all other outputs 0, including dut_pi, dut_key, rsp_* and query_cnt.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - pat_ready=1.
  - On pat_valid&pat_ready at edge E0: register pat_pi into dut_pi and rsp_pi, and pat_key into dut_key.
  - Load settle counter with SETTLE_CYC-1, then go to SETTLE.
- SETTLE:
  - pat_ready=0; counter decrements each cycle.
  - On the edge where the counter is 0: sample dut_po into rsp_po, set rsp_valid=1, go to RESP.
  - rsp_valid is therefore first high SETTLE_CYC cycles after E0.
- RESP:
  - rsp_valid, rsp_pi, rsp_po and rsp_err are held stable until rsp_ready is sampled high.
  - On the handshake: rsp_valid=0, query_cnt+1 (saturating at all-ones), back to IDLE.
  - pat_ready returns high the cycle after the handshake, so back-to-back throughput is one query per SETTLE_CYC+2 cycles.
- dut_pi and dut_key change only on an accepted pattern and hold between queries, so the oracle never sees a glitch or a spurious value in IDLE.
- pat_pi and pat_key are ignored unless a handshake occurs.
- cnt_clr:
  - Clears query_cnt next edge.
  - If asserted in the same cycle as a response handshake, the clear wins and query_cnt becomes 0.
- rst_n asserted mid-query: query is dropped with no response; all state returns to reset values immediately (async).
- rsp_ready high in IDLE or SETTLE: ignored.

Optional Feature:
- Macro: C432_KEY_ALLOW_FILTER_EN.
- When defined:
  - Adds parameter KEY_ALLOW_MASK (1<<KEY_W bits, default 4'b1111). Bit k=1 means key value k is an allowed camouflage configuration.
  - An accepted pattern with a disallowed key skips SETTLE and enters RESP on the next edge with rsp_err=1 and rsp_po=0.
  - For a rejected query, dut_pi and dut_key are NOT updated; rsp_pi still echoes pat_pi.
  - The count still increments on the handshake.
- When undefined: no parameter; rsp_err tied to 0; every key is applied.

Test Plan:
- Reset, then pattern pi=36'h0_0000_0001, key=2'b00, SETTLE_CYC=2, stub dut_po=7'h55 -> rsp_valid high 2 cycles after accept; rsp_po=7'h55, rsp_pi echo correct; query_cnt=1.
- Hold rsp_ready=0 for 5 cycles while the stub changes dut_po -> rsp_po stays stable and pat_ready stays 0; on rsp_ready=1, rsp_valid drops and pat_ready rises the next cycle.
- 3 back-to-back patterns with rsp_ready tied 1 -> exactly 3 responses in order, query_cnt=3, dut_pi holds the third pattern afterwards.
- rst_n pulsed low during SETTLE -> no response; rsp_valid=0, dut_pi=0, query_cnt=0, pat_ready=1 after release.
- cnt_clr coincident with a response handshake when query_cnt=5 -> query_cnt=0. Saturation check with CNT_W=2: 4 queries -> query_cnt=3.
- With C432_KEY_ALLOW_FILTER_EN, KEY_ALLOW_MASK=4'b1011, key=2'b10 -> rsp_err=1, rsp_po=0, dut_key unchanged, response 1 cycle after accept; key=2'b01 -> normal query with rsp_err=0.

Source files
------------

// File: rtl/c432_oracle_query_seq.sv
// Query sequencer feeding the camouflaged c432 netlist: applies a PI pattern
// and camouflage key, waits a fixed settle time, captures the POs and returns
// the I/O pair to the SAT host. One query in flight; completed queries counted.
// Optional feature macro: C432_KEY_ALLOW_FILTER_EN (reject disallowed keys).
module c432_oracle_query_seq #(
  parameter int unsigned PI_W       = 36,
  parameter int unsigned PO_W       = 7,
  parameter int unsigned KEY_W      = 2,
  parameter int          SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 16
`ifdef C432_KEY_ALLOW_FILTER_EN
  , parameter logic [(1<<KEY_W)-1:0] KEY_ALLOW_MASK = '1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PI_W-1:0]  pat_pi,
  input  logic [KEY_W-1:0] pat_key,
  output logic [PI_W-1:0]  dut_pi,
  output logic [KEY_W-1:0] dut_key,
  input  logic [PO_W-1:0]  dut_po,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PI_W-1:0]  rsp_pi,
  output logic [PO_W-1:0]  rsp_po,
  output logic             rsp_err,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] query_cnt
);

  // Settle times below one cycle are clamped to one.
  localparam int unsigned SETTLE_EFF = (SETTLE_CYC < 1) ? 32'd1 : 32'(SETTLE_CYC);
  localparam int unsigned SCNT_W     = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t             state_q, state_nx;
  logic [SCNT_W-1:0]  scnt_q, scnt_nx;
  logic [PI_W-1:0]    dut_pi_nx, rsp_pi_nx;
  logic [KEY_W-1:0]   dut_key_nx;
  logic [PO_W-1:0]    rsp_po_nx;
  logic               rsp_valid_nx, rsp_err_q, rsp_err_nx;
  logic               pat_ready_nx, busy_nx;
  logic [CNT_W-1:0]   cnt_nx;
  logic               rej_q, rej_nx;
  logic               key_ok;

`ifdef C432_KEY_ALLOW_FILTER_EN
  assign key_ok = KEY_ALLOW_MASK[pat_key];
`else
  assign key_ok = 1'b1;
`endif

  // State and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      dut_pi    <= '0;
      dut_key   <= '0;
      rsp_valid <= 1'b0;
      rsp_pi    <= '0;
      rsp_po    <= '0;
      rsp_err_q <= 1'b0;
      rej_q     <= 1'b0;
      pat_ready <= 1'b1;
      busy      <= 1'b0;
      query_cnt <= '0;
    end else begin
      state_q   <= state_nx;
      scnt_q    <= scnt_nx;
      dut_pi    <= dut_pi_nx;
      dut_key   <= dut_key_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_pi    <= rsp_pi_nx;
      rsp_po    <= rsp_po_nx;
      rsp_err_q <= rsp_err_nx;
      rej_q     <= rej_nx;
      pat_ready <= pat_ready_nx;
      busy      <= busy_nx;
      query_cnt <= cnt_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state_q;
    scnt_nx      = scnt_q;
    dut_pi_nx    = dut_pi;
    dut_key_nx   = dut_key;
    rsp_valid_nx = rsp_valid;
    rsp_pi_nx    = rsp_pi;
    rsp_po_nx    = rsp_po;
    rsp_err_nx   = rsp_err_q;
    rej_nx       = rej_q;
    cnt_nx       = query_cnt;

    case (state_q)
      IDLE: begin
        if (pat_valid) begin
          rsp_pi_nx = pat_pi;
          state_nx  = SETTLE;
          if (key_ok) begin
            dut_pi_nx  = pat_pi;
            dut_key_nx = pat_key;
            scnt_nx    = SCNT_LOAD;
            rej_nx     = 1'b0;
          end else begin
            // Rejected key: oracle pins untouched, respond on the next edge.
            scnt_nx = '0;
            rej_nx  = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (scnt_q == '0) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_po_nx    = rej_q ? '0 : dut_po;
          rsp_err_nx   = rej_q;
        end else begin
          scnt_nx = scnt_q - SCNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          rsp_err_nx   = 1'b0;
          if (query_cnt != '1) cnt_nx = query_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    if (cnt_clr) cnt_nx = '0;

    pat_ready_nx = (state_nx == IDLE);
    busy_nx      = (state_nx != IDLE);
  end

  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_c432_oracle_query_seq.sv
// Self-checking bench for c432_oracle_query_seq: table-driven queries,
// scoreboard on the response channel, plus multi-cycle corner sequences.
module tb_c432_oracle_query_seq;

  localparam int unsigned PI_W = 36;
  localparam int unsigned PO_W = 7;
  localparam int unsigned KEY_W = 2;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pat_valid = 1'b0;
  logic [PI_W-1:0] pat_pi = '0;
  logic [KEY_W-1:0] pat_key = '0;
  logic [PO_W-1:0] po_stub = '0;
  logic rsp_ready = 1'b0;
  logic cnt_clr = 1'b0;

  logic pat_ready, rsp_valid, rsp_err, busy;
  logic [PI_W-1:0] dut_pi, rsp_pi;
  logic [KEY_W-1:0] dut_key;
  logic [PO_W-1:0] rsp_po;
  logic [15:0] query_cnt;

  logic s_pat_ready, s_rsp_valid, s_rsp_err, s_busy;
  logic [PI_W-1:0] s_dut_pi, s_rsp_pi;
  logic [KEY_W-1:0] s_dut_key;
  logic [PO_W-1:0] s_rsp_po;
  logic [1:0] s_query_cnt;

  always #5 clk = ~clk;

  c432_oracle_query_seq #(
    .PI_W(PI_W), .PO_W(PO_W), .KEY_W(KEY_W), .SETTLE_CYC(SETTLE), .CNT_W(16)
`ifdef C432_KEY_ALLOW_FILTER_EN
    , .KEY_ALLOW_MASK(4'b1011)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_pi(pat_pi), .pat_key(pat_key), .dut_pi(dut_pi), .dut_key(dut_key),
    .dut_po(po_stub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_pi(rsp_pi), .rsp_po(rsp_po), .rsp_err(rsp_err), .busy(busy),
    .cnt_clr(cnt_clr), .query_cnt(query_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  c432_oracle_query_seq #(
    .PI_W(PI_W), .PO_W(PO_W), .KEY_W(KEY_W), .SETTLE_CYC(SETTLE), .CNT_W(2)
`ifdef C432_KEY_ALLOW_FILTER_EN
    , .KEY_ALLOW_MASK(4'b1011)
`endif
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(s_pat_ready),
    .pat_pi(pat_pi), .pat_key(pat_key), .dut_pi(s_dut_pi), .dut_key(s_dut_key),
    .dut_po(po_stub), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_pi(s_rsp_pi), .rsp_po(s_rsp_po), .rsp_err(s_rsp_err), .busy(s_busy),
    .cnt_clr(cnt_clr), .query_cnt(s_query_cnt)
  );

  typedef struct {
    logic [PI_W-1:0] pi;
    logic [PO_W-1:0] po;
    logic            err;
  } sb_item_t;

  typedef struct {
    logic [PI_W-1:0]  pi;
    logic [KEY_W-1:0] key;
    logic [PO_W-1:0]  po;
    int               hold;
    logic [15:0]      exp_cnt;
    logic [1:0]       exp_sat;
  } vec_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_rsp = 0;
  logic [PI_W-1:0] last_pi = '0;
  logic [KEY_W-1:0] last_key = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got response pi=%0h with empty scoreboard", rsp_pi);
      end else begin
        sb_item_t it;
        it = sb.pop_front();
        chk("rsp_pi", 64'(rsp_pi), 64'(it.pi));
        chk("rsp_po", 64'(rsp_po), 64'(it.po));
        chk("rsp_err", 64'(rsp_err), 64'(it.err));
        chk("sat_rsp", {s_rsp_err, s_rsp_po, s_rsp_pi}, {it.err, it.po, it.pi});
      end
    end
  end

  // One full query with optional response back-pressure.
  task automatic do_query(input logic [PI_W-1:0] pi, input logic [KEY_W-1:0] key,
                          input logic [PO_W-1:0] po, input int hold, input logic clr,
                          input logic exp_err, input logic [15:0] exp_cnt,
                          input logic [1:0] exp_sat);
    int n;
    sb_item_t it;
    chk("pat_ready_idle", 64'(pat_ready), 64'd1);
    pat_valid = 1'b1;
    pat_pi = pi;
    pat_key = key;
    po_stub = po;
    it.pi = pi;
    it.po = exp_err ? '0 : po;
    it.err = exp_err;
    sb.push_back(it);
    if (!exp_err) begin
      last_pi = pi;
      last_key = key;
    end
    @(posedge clk); #1;
    pat_valid = 1'b0;
    pat_pi = PI_W'({$urandom(), $urandom()});
    pat_key = KEY_W'($urandom());
    chk("busy_after_accept", {busy, pat_ready}, 2'b10);
    chk("dut_pi_drive", 64'(dut_pi), 64'(last_pi));
    chk("dut_key_drive", 64'(dut_key), 64'(last_key));
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", 64'(n), exp_err ? 64'd1 : 64'(SETTLE));
    for (int h = 0; h < hold; h++) begin
      po_stub = ~po;
      @(posedge clk); #1;
      chk("hold_stable", {rsp_valid, pat_ready, rsp_po}, {1'b1, 1'b0, it.po});
    end
    rsp_ready = 1'b1;
    cnt_clr = clr;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cnt_clr = 1'b0;
    chk("post_hs", {rsp_valid, pat_ready, busy}, 3'b010);
    chk("query_cnt", 64'(query_cnt), 64'(exp_cnt));
    chk("sat_query_cnt", 64'(s_query_cnt), 64'(exp_sat));
    chk("sat_idle", {s_pat_ready, s_busy, s_rsp_valid, s_rsp_err, s_dut_key, s_dut_pi},
        {4'b1000, last_key, last_pi});
  endtask

  vec_t vecs[5];
  logic [PI_W-1:0] bb_pi[3];
  logic [PO_W-1:0] bb_po[3];

  initial begin
    int n;
    int rsp0;
    vecs[0] = '{36'h0_0000_0001, 2'b00, 7'h55, 0, 16'd1, 2'd1};
    vecs[1] = '{36'h8_0000_0000, 2'b01, 7'h2A, 5, 16'd2, 2'd2};
    vecs[2] = '{36'hF_FFFF_FFFF, 2'b11, 7'h7F, 1, 16'd3, 2'd3};
    vecs[3] = '{36'h5_A5A5_A5A5, 2'b01, 7'h00, 0, 16'd4, 2'd3};
    vecs[4] = '{36'hA_5A5A_5A5A, 2'b00, 7'h3C, 2, 16'd5, 2'd3};
    bb_pi[0] = 36'h1_1111_1111; bb_po[0] = 7'h01;
    bb_pi[1] = 36'h2_2222_2222; bb_po[1] = 7'h12;
    bb_pi[2] = 36'h3_3333_3333; bb_po[2] = 7'h63;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {pat_ready, busy, rsp_valid, rsp_err}, 4'b1000);
    chk("reset_data", {dut_key, dut_pi, rsp_pi, rsp_po}, '0);
    chk("reset_cnt", 64'(query_cnt), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of normal queries, including back-pressure and counter saturation.
    for (int i = 0; i < 5; i++)
      do_query(vecs[i].pi, vecs[i].key, vecs[i].po, vecs[i].hold, 1'b0, 1'b0,
               vecs[i].exp_cnt, vecs[i].exp_sat);

    // Clear coincident with a response handshake at query_cnt=5.
    do_query(36'h1_2345_6789, 2'b11, 7'h11, 0, 1'b1, 1'b0, 16'd0, 2'd0);

    // Back-to-back queries with rsp_ready tied high.
    rsp0 = n_rsp;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!pat_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (i > 0) chk("b2b_gap", 64'(n + 1), 64'(SETTLE + 2));
      pat_valid = 1'b1;
      pat_pi = bb_pi[i];
      pat_key = 2'b01;
      po_stub = bb_po[i];
      sb.push_back('{bb_pi[i], bb_po[i], 1'b0});
      @(posedge clk); #1;
      pat_valid = 1'b0;
    end
    last_pi = bb_pi[2];
    last_key = 2'b01;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    rsp_ready = 1'b0;
    chk("b2b_responses", 64'(n_rsp - rsp0), 64'd3);
    chk("b2b_cnt", 64'(query_cnt), 64'd3);
    chk("b2b_dut_pi", 64'(dut_pi), 64'(bb_pi[2]));

    // Reset pulsed during SETTLE drops the query.
    rsp0 = n_rsp;
    pat_valid = 1'b1;
    pat_pi = 36'h7_7777_7777;
    pat_key = 2'b11;
    @(posedge clk); #1;
    pat_valid = 1'b0;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {rsp_valid, busy, pat_ready}, 3'b001);
    chk("async_reset_data", {dut_key, dut_pi}, '0);
    chk("async_reset_cnt", 64'(query_cnt), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    last_pi = '0;
    last_key = '0;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("no_rsp_after_reset", {64'(n_rsp - rsp0)}, 64'd0);
    chk("idle_after_reset", {rsp_valid, pat_ready, busy}, 3'b010);

    do_query(36'h0_DEAD_BEEF, 2'b00, 7'h4B, 0, 1'b0, 1'b0, 16'd1, 2'd1);
`ifdef C432_KEY_ALLOW_FILTER_EN
    // Disallowed key under mask 4'b1011, then an allowed one.
    do_query(36'h9_8765_4321, 2'b10, 7'h5A, 1, 1'b0, 1'b1, 16'd2, 2'd2);
    do_query(36'h4_4444_4444, 2'b01, 7'h66, 0, 1'b0, 1'b0, 16'd3, 2'd3);
`else
    do_query(36'h9_8765_4321, 2'b10, 7'h5A, 1, 1'b0, 1'b0, 16'd2, 2'd2);
`endif
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
